cb_rr: RTL

Parametrised input-to-output crossbar for the router datapath. It combines per-output round-robin arbitration, wormhole packet locking, a per-input forward-abort, and an optional output register stage. It sits between the VC/switch-allocation stage and the output link registers, and is the successor of the fixed 5-port crossbar.

---
 rtl/cb_rr.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/cb_rr.sv
// ---------------------------------------------------------------------------
// cb_rr -- PORTS x PORTS router crossbar with per-output round-robin
// arbitration, wormhole packet locking and a per-input forward-abort.
//
// Optional feature macro: CB_OUTREG_EN
//   defined   : odata/ovalid/ovch are registered (1 cycle after the grant)
//   undefined : odata/ovalid/ovch are combinational in the grant cycle
// Arbitration, locking and grt timing are the same in both builds.
//
// Ports (per-port buses are flattened, port k occupies slice k):
//   clk     in   clock
//   rst_    in   synchronous active-low reset
//   idata   in   PORTS*DATAW  input flit data
//   ivalid  in   PORTS        input flit valid
//   ivch    in   PORTS*VCHW   input VC id
//   itail   in   PORTS        flit is the packet tail
//   port    in   PORTS*PORTW  requested output port per input
//   req     in   PORTS        switch request per input
//   fwdab   in   PORTS        forward-abort per input (drops that input's lock)
//   grt     out  PORTS*PORTS  bit i*PORTS+j : input i has won output j
//   odata   out  PORTS*DATAW  output flit data
//   ovalid  out  PORTS        output flit valid
//   ovch    out  PORTS*VCHW   output VC id
//   lock    out  PORTS        output j is locked to a packet (status)
//
// Handshake: a flit moves from input i to output j in the cycle grt bit
// i*PORTS+j is high; the upstream allocator must treat that grant as the
// acceptance of the flit. There is no backpressure from the output side.
// ---------------------------------------------------------------------------
module cb_rr #(
    parameter  int PORTS = 5,
    parameter  int DATAW = 64,
    parameter  int VCHW  = 2,
    localparam int PORTW = $clog2(PORTS)
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [PORTS*DATAW-1:0] idata,
    input  logic [PORTS-1:0]       ivalid,
    input  logic [PORTS*VCHW-1:0]  ivch,
    input  logic [PORTS-1:0]       itail,
    input  logic [PORTS*PORTW-1:0] port,
    input  logic [PORTS-1:0]       req,
    input  logic [PORTS-1:0]       fwdab,
    output logic [PORTS*PORTS-1:0] grt,
    output logic [PORTS*DATAW-1:0] odata,
    output logic [PORTS-1:0]       ovalid,
    output logic [PORTS*VCHW-1:0]  ovch,
    output logic [PORTS-1:0]       lock
);

    // Per-output state: lock flag, owning input, round-robin pointer.
    logic [PORTS-1:0] lk_q, lk_d;
    logic [PORTW-1:0] own_q [PORTS];
    logic [PORTW-1:0] own_d [PORTS];
    logic [PORTW-1:0] ptr_q [PORTS];
    logic [PORTW-1:0] ptr_d [PORTS];

    // req_hit[i][j]: input i requests output j. Out-of-range port values
    // never compare equal to any j and are silently ignored.
    logic [PORTS-1:0] req_hit [PORTS];
    logic [PORTS-1:0] gnt_raw;
    logic [PORTS-1:0] gnt;
    logic [PORTW-1:0] win [PORTS];

    logic [PORTS*DATAW-1:0] odata_d;
    logic [PORTS-1:0]       ovalid_d;
    logic [PORTS*VCHW-1:0]  ovch_d;

    function automatic logic [PORTW-1:0] next_port(input logic [PORTW-1:0] p);
        if (int'(p) == PORTS - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            for (int j = 0; j < PORTS; j++) begin
                req_hit[i][j] = req[i] && (port[i*PORTW +: PORTW] == PORTW'(j));
            end
        end
    end

    // Arbitration and next-state for every output.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_raw = '0;
        lk_d    = lk_q;
        for (int j = 0; j < PORTS; j++) begin
            win[j]   = '0;
            own_d[j] = own_q[j];
            ptr_d[j] = ptr_q[j];
        end

        for (int j = 0; j < PORTS; j++) begin
            if (lk_q[j]) begin
                // Locked: only the owner may be granted; its abort beats its
                // own request and frees the output for the next cycle.
                if (fwdab[own_q[j]]) begin
                    lk_d[j]  = 1'b0;
                    ptr_d[j] = next_port(own_q[j]);
                end else if (req_hit[own_q[j]][j]) begin
                    gnt_raw[j] = 1'b1;
                    win[j]     = own_q[j];
                end
            end else begin
                // Unlocked: first requester scanning ptr, ptr+1, ... mod PORTS.
                for (int k = 0; k < PORTS; k++) begin
                    idx = int'(ptr_q[j]) + k;
                    if (idx >= PORTS) begin
                        idx = idx - PORTS;
                    end
                    if (!gnt_raw[j] && req_hit[idx][j]) begin
                        gnt_raw[j] = 1'b1;
                        win[j]     = PORTW'(idx);
                    end
                end
            end

            if (gnt_raw[j]) begin
                if (itail[win[j]]) begin
                    // Pointer advances only at packet end: packet-level fairness.
                    lk_d[j]  = 1'b0;
                    ptr_d[j] = next_port(win[j]);
                end else begin
                    lk_d[j]  = 1'b1;
                    own_d[j] = win[j];
                end
            end
        end
    end

    // No grants are visible while reset is asserted.
    assign gnt = gnt_raw & {PORTS{rst_}};

    always_comb begin
        grt = '0;
        for (int j = 0; j < PORTS; j++) begin
            for (int i = 0; i < PORTS; i++) begin
                grt[i*PORTS+j] = gnt[j] && (win[j] == PORTW'(i));
            end
        end
    end

    // Output mux: zero when the output has no grant.
    always_comb begin
        odata_d  = '0;
        ovalid_d = '0;
        ovch_d   = '0;
        for (int j = 0; j < PORTS; j++) begin
            if (gnt[j]) begin
                odata_d[j*DATAW +: DATAW] = idata[int'(win[j])*DATAW +: DATAW];
                ovch_d[j*VCHW +: VCHW]    = ivch[int'(win[j])*VCHW +: VCHW];
                ovalid_d[j]               = ivalid[win[j]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            lk_q <= '0;
            for (int j = 0; j < PORTS; j++) begin
                own_q[j] <= '0;
                ptr_q[j] <= '0;
            end
        end else begin
            lk_q <= lk_d;
            for (int j = 0; j < PORTS; j++) begin
                own_q[j] <= own_d[j];
                ptr_q[j] <= ptr_d[j];
            end
        end
    end

    assign lock = lk_q;

`ifdef CB_OUTREG_EN
    logic [PORTS*DATAW-1:0] odata_q;
    logic [PORTS-1:0]       ovalid_q;
    logic [PORTS*VCHW-1:0]  ovch_q;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            odata_q  <= '0;
            ovalid_q <= '0;
            ovch_q   <= '0;
        end else begin
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            ovch_q   <= ovch_d;
        end
    end

    assign odata  = odata_q;
    assign ovalid = ovalid_q;
    assign ovch   = ovch_q;
`else
    assign odata  = odata_d;
    assign ovalid = ovalid_d;
    assign ovch   = ovch_d;
`endif

endmodule
